// File: rtl/boot_reset_sequencer.sv
// Boot/recovery reset sequencer for the sys_clk domain.
// Waits for PLL lock, holds a stabilisation delay, then releases the capture,
// audio and HDMI resets one step at a time. A debounced button press or a loss
// of PLL lock re-asserts every reset at once and restarts the sequence.
module boot_reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STABLE_CYCLES   = 16777215,
  parameter int STEP_CYCLES     = 1024,
  parameter int CNT_W           = 24
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       pll_locked,
  input  logic       btn_rst_n,
  output logic       rst_capture,
  output logic       rst_audio,
  output logic       rst_hdmi,
  output logic       boot_done,
  output logic [2:0] state_o,
  output logic [7:0] relock_count
);

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_STABILIZE   = 3'd2,
    ST_REL_CAPTURE = 3'd3,
    ST_REL_AUDIO   = 3'd4,
    ST_REL_HDMI    = 3'd5,
    ST_RUN         = 3'd6,
    ST_UNUSED      = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Saturating increment for the lock-loss counter; sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             lock_p0, lock_s;
  logic             btn_p0, btn_s;
  logic             btn_pressed;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] delay_cnt;
  state_t           state, state_next;
  logic             cnt_clr;
  logic             abort;
  logic             relock_inc;

  // Two-flop synchronisers; lock starts "unlocked", button starts "released".
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
      btn_p0  <= 1'b1;
      btn_s   <= 1'b1;
    end else begin
      lock_p0 <= pll_locked;
      lock_s  <= lock_p0;
      btn_p0  <= btn_rst_n;
      btn_s   <= btn_p0;
    end
  end

  // Debouncer: the state flips only after DEBOUNCE_CYCLES consecutive
  // opposite samples; a sample agreeing with the current state restarts it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      deb_cnt     <= '0;
      btn_pressed <= 1'b0;
    end else if (~btn_s == btn_pressed) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt     <= '0;
      btn_pressed <= ~btn_s;
    end else begin
      deb_cnt <= deb_cnt + CNT_ONE;
    end
  end

  // Next-state logic; abort outranks count completion in every timed state.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b1;
    abort      = ~lock_s | btn_pressed;
    case (state)
      ST_RESET:     state_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_s && !btn_pressed) state_next = ST_STABILIZE;
      ST_STABILIZE: begin
        if (abort)                          state_next = ST_WAIT_LOCK;
        else if (delay_cnt == STABLE_LAST)  state_next = ST_REL_CAPTURE;
        else                                cnt_clr    = 1'b0;
      end
      ST_REL_CAPTURE: begin
        if (abort)                          state_next = ST_WAIT_LOCK;
        else if (delay_cnt == STEP_LAST)    state_next = ST_REL_AUDIO;
        else                                cnt_clr    = 1'b0;
      end
      ST_REL_AUDIO: begin
        if (abort)                          state_next = ST_WAIT_LOCK;
        else if (delay_cnt == STEP_LAST)    state_next = ST_REL_HDMI;
        else                                cnt_clr    = 1'b0;
      end
      ST_REL_HDMI: begin
        if (abort)                          state_next = ST_WAIT_LOCK;
        else if (delay_cnt == STEP_LAST)    state_next = ST_RUN;
        else                                cnt_clr    = 1'b0;
      end
      ST_RUN:       if (abort) state_next = ST_WAIT_LOCK;
      default:      state_next = ST_RESET;
    endcase
  end

  // Only a lock loss out of RUN counts; a button-only abort does not.
  assign relock_inc = (state == ST_RUN) && !lock_s;

  // Shared delay counter: runs within a timed state, clears on every change.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)      delay_cnt <= '0;
    else if (cnt_clr) delay_cnt <= '0;
    else              delay_cnt <= delay_cnt + CNT_ONE;
  end

  // State register plus outputs decoded from next state so they move with it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= ST_RESET;
      rst_capture  <= 1'b1;
      rst_audio    <= 1'b1;
      rst_hdmi     <= 1'b1;
      boot_done    <= 1'b0;
      relock_count <= 8'd0;
    end else begin
      state        <= state_next;
      rst_capture  <= (state_next < ST_REL_CAPTURE);
      rst_audio    <= (state_next < ST_REL_AUDIO);
      rst_hdmi     <= (state_next < ST_REL_HDMI);
      boot_done    <= (state_next == ST_RUN);
      if (relock_inc) relock_count <= sat_inc8(relock_count);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_boot_reset_sequencer.sv
// Directed bench for boot_reset_sequencer with a scoreboard of expected
// observations: each entry says how many clock edges to advance and what the
// outputs must then be.
module tb_boot_reset_sequencer;

  localparam int DEB  = 4;
  localparam int STAB = 16;
  localparam int STEP = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       pll_locked;
  logic       btn_rst_n;
  logic       rst_capture, rst_audio, rst_hdmi, boot_done;
  logic [2:0] state_o;
  logic [7:0] relock_count;

  boot_reset_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .STABLE_CYCLES  (STAB),
    .STEP_CYCLES    (STEP),
    .CNT_W          (8)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pll_locked   (pll_locked),
    .btn_rst_n    (btn_rst_n),
    .rst_capture  (rst_capture),
    .rst_audio    (rst_audio),
    .rst_hdmi     (rst_hdmi),
    .boot_done    (boot_done),
    .state_o      (state_o),
    .relock_count (relock_count)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    string      tag;
    int         delay;
    logic [2:0] st;
    logic [2:0] rsts;   // {capture, audio, hdmi}
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input int d, input logic [2:0] st,
                      input logic [2:0] rsts, input logic done, input logic [7:0] cnt);
    exp_t e;
    e.tag = tag; e.delay = d; e.st = st; e.rsts = rsts; e.done = done; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Full release sequence: STABILIZE entry d edges from now, then each step.
  task automatic push_boot(input string tag, input int d, input logic [7:0] cnt);
    push({tag, "_stab"},     d,        3'd2, 3'b111, 1'b0, cnt);
    push({tag, "_stab_end"}, STAB - 1, 3'd2, 3'b111, 1'b0, cnt);
    push({tag, "_cap"},      1,        3'd3, 3'b011, 1'b0, cnt);
    push({tag, "_cap_end"},  STEP - 1, 3'd3, 3'b011, 1'b0, cnt);
    push({tag, "_aud"},      1,        3'd4, 3'b001, 1'b0, cnt);
    push({tag, "_aud_end"},  STEP - 1, 3'd4, 3'b001, 1'b0, cnt);
    push({tag, "_hdmi"},     1,        3'd5, 3'b000, 1'b0, cnt);
    push({tag, "_hdmi_end"}, STEP - 1, 3'd5, 3'b000, 1'b0, cnt);
    push({tag, "_run"},      1,        3'd6, 3'b000, 1'b1, cnt);
  endtask

  task automatic drain();
    exp_t        e;
    logic [14:0] obs;
    logic [14:0] want;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tick(e.delay);
      obs  = {state_o, rst_capture, rst_audio, rst_hdmi, boot_done, relock_count};
      want = {e.st, e.rsts, e.done, e.cnt};
      n_checks++;
      assert (obs === want) else begin
        n_errors++;
        $error("FAIL %s: observed state=%0d rst=%b done=%b relock=%0d, expected state=%0d rst=%b done=%b relock=%0d",
               e.tag, obs[14:12], obs[11:9], obs[8], obs[7:0],
               want[14:12], want[11:9], want[8], want[7:0]);
      end
    end
  endtask

  initial begin
    sys_rst    = 1'b1;
    pll_locked = 1'b1;
    btn_rst_n  = 1'b1;
    tick(3);
    push("reset", 0, 3'd0, 3'b111, 1'b0, 8'd0);
    drain();

    // 1: cold boot. Lock reaches lock_s two edges after release.
    sys_rst = 1'b0;
    push("s1_wait", 1, 3'd1, 3'b111, 1'b0, 8'd0);
    push("s1_wait_sync", 1, 3'd1, 3'b111, 1'b0, 8'd0);
    push_boot("s1", 1, 8'd0);
    drain();

    // 2: two-cycle lock loss in RUN; resets three edges after the fall.
    pll_locked = 1'b0;
    push("s2_pre_abort", 2, 3'd6, 3'b000, 1'b1, 8'd0);
    drain();
    pll_locked = 1'b1;
    push("s2_abort", 1, 3'd1, 3'b111, 1'b0, 8'd1);
    push("s2_wait", 1, 3'd1, 3'b111, 1'b0, 8'd1);
    push_boot("s2", 1, 8'd1);
    drain();

    // 3a: short press (3 cycles) is filtered out.
    btn_rst_n = 1'b0;
    tick(3);
    btn_rst_n = 1'b1;
    push("s3_short", 8, 3'd6, 3'b000, 1'b1, 8'd1);
    drain();
    // 3b: long press. 2 sync edges + DEB samples + 1 state edge = 7.
    btn_rst_n = 1'b0;
    push("s3_pre_abort", 2 + DEB, 3'd6, 3'b000, 1'b1, 8'd1);
    push("s3_abort", 1, 3'd1, 3'b111, 1'b0, 8'd1);
    drain();
    tick(3);
    btn_rst_n = 1'b1;
    push("s3_hold", 2 + DEB, 3'd1, 3'b111, 1'b0, 8'd1);
    push_boot("s3", 1, 8'd1);
    drain();

    // 5: build count to 2, then async reset during REL_AUDIO.
    pll_locked = 1'b0;
    push("s5_abort", 3, 3'd1, 3'b111, 1'b0, 8'd2);
    drain();
    pll_locked = 1'b1;
    push("s5_stab", 3, 3'd2, 3'b111, 1'b0, 8'd2);
    push("s5_cap", STAB, 3'd3, 3'b011, 1'b0, 8'd2);
    push("s5_aud", STEP, 3'd4, 3'b001, 1'b0, 8'd2);
    push("s5_aud_mid", 3, 3'd4, 3'b001, 1'b0, 8'd2);
    drain();
    sys_rst = 1'b1;
    #2;
    push("s5_async_rst", 0, 3'd0, 3'b111, 1'b0, 8'd0);
    push("s5_rst_hold", 1, 3'd0, 3'b111, 1'b0, 8'd0);
    drain();
    sys_rst = 1'b0;

    // 4: lock loss at STABILIZE count 10; relock restarts the full delay.
    push("s4_wait", 1, 3'd1, 3'b111, 1'b0, 8'd0);
    push("s4_wait_sync", 1, 3'd1, 3'b111, 1'b0, 8'd0);
    push("s4_stab", 1, 3'd2, 3'b111, 1'b0, 8'd0);
    push("s4_cnt10", 10, 3'd2, 3'b111, 1'b0, 8'd0);
    drain();
    pll_locked = 1'b0;
    push("s4_pre_abort", 2, 3'd2, 3'b111, 1'b0, 8'd0);
    push("s4_abort", 1, 3'd1, 3'b111, 1'b0, 8'd0);
    drain();
    pll_locked = 1'b1;
    push_boot("s4", 3, 8'd0);
    drain();

    // 6a: 300 lock losses from RUN; counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick(2);
      pll_locked = 1'b1;
      push($sformatf("s6_sat%0d", i), 3 + STAB + 3 * STEP, 3'd6, 3'b000, 1'b1,
           (i + 1 > 255) ? 8'd255 : 8'(i + 1));
      drain();
    end

    // 6b: abort lands on the same edge as the last REL_HDMI count.
    pll_locked = 1'b0;
    push("s6_pre", 2, 3'd6, 3'b000, 1'b1, 8'd255);
    drain();
    pll_locked = 1'b1;
    push("s6_stab", 3, 3'd2, 3'b111, 1'b0, 8'd255);
    push("s6_hdmi", STAB + 2 * STEP, 3'd5, 3'b000, 1'b0, 8'd255);
    push("s6_hdmi_mid", STEP - 3, 3'd5, 3'b000, 1'b0, 8'd255);
    drain();
    pll_locked = 1'b0;
    push("s6_hdmi_last", 2, 3'd5, 3'b000, 1'b0, 8'd255);
    push("s6_race", 1, 3'd1, 3'b111, 1'b0, 8'd255);
    push("s6_after", 1, 3'd1, 3'b111, 1'b0, 8'd255);
    drain();
    pll_locked = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
